// File: rtl/sys_pkg.sv
// Shared types and sizes for the 4x4 int8 systolic tile scheduler.
// The tile geometry lives here so the sequencer and skew line agree on it.
package sys_pkg;

    localparam int ARRAY_DIM = 4;
    localparam int LANE_W    = 8;
    localparam int ACC_W     = 32;
    localparam int WORD_W    = ARRAY_DIM * LANE_W;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        FLUSH,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/sys_skew_line.sv
// Four-lane int8 diagonal skew: lane i leaves i cycles after it enters.
// Slots without valid read data carry zero so the array never sees stale bytes.
module sys_skew_line
    import sys_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] din,
    output logic [WORD_W-1:0] dout
);

    for (genvar i = 0; i < ARRAY_DIM; i++) begin : g_lane
        logic [LANE_W-1:0] lane_in;
        assign lane_in = in_valid ? din[LANE_W*i +: LANE_W] : '0;

        if (i == 0) begin : g_direct
            assign dout[LANE_W*i +: LANE_W] = lane_in;
        end else begin : g_delay
            logic [LANE_W-1:0] pipe [i];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int j = 0; j < i; j++) pipe[j] <= '0;
                end else if (flush) begin
                    for (int j = 0; j < i; j++) pipe[j] <= '0;
                end else begin
                    pipe[0] <= lane_in;
                    for (int j = 1; j < i; j++) pipe[j] <= pipe[j-1];
                end
            end

            assign dout[LANE_W*i +: LANE_W] = pipe[i-1];
        end
    end

endmodule

// File: rtl/sys_tile_sched.sv
// Sequencer for one 4x4 int8 tile: clear, stream K words with skew, flush the
// array, then drain the 16 int32 results to the C writer over valid/ready.
module sys_tile_sched
    import sys_pkg::*;
#(
    parameter int BRAM_ADDR_WIDTH = 11,
    parameter int K_WIDTH         = 16,
    parameter int FLUSH_CYCLES    = 11
) (
    input  logic                                   s_axi_aclk,
    input  logic                                   s_axi_aresetn,
    input  logic                                   cmd_valid,
    output logic                                   cmd_ready,
    input  logic [BRAM_ADDR_WIDTH-1:0]             cmd_a_base,
    input  logic [BRAM_ADDR_WIDTH-1:0]             cmd_b_base,
    input  logic [BRAM_ADDR_WIDTH-1:0]             cmd_c_base,
    input  logic [K_WIDTH-1:0]                     cmd_k_len,
    input  logic                                   cmd_accumulate,
    input  logic                                   abort,
    output logic [BRAM_ADDR_WIDTH-1:0]             bram_a_addrb,
    output logic [BRAM_ADDR_WIDTH-1:0]             bram_b_addrb,
    output logic                                   bram_a_enb,
    output logic                                   bram_b_enb,
    input  logic [WORD_W-1:0]                      bram_a_doutb,
    input  logic [WORD_W-1:0]                      bram_b_doutb,
    output logic                                   arr_clear,
    output logic [WORD_W-1:0]                      arr_a,
    output logic [WORD_W-1:0]                      arr_b,
    input  logic [ARRAY_DIM*ARRAY_DIM*ACC_W-1:0]   arr_c_flat,
    output logic                                   res_valid,
    input  logic                                   res_ready,
    output logic [BRAM_ADDR_WIDTH-1:0]             res_addr,
    output logic [ACC_W-1:0]                       res_data,
    output logic                                   busy,
    output logic                                   done
);

    localparam int FC_W  = $clog2(FLUSH_CYCLES + 1);
    localparam int IDX_W = $clog2(ARRAY_DIM * ARRAY_DIM);

    state_t                     state, state_next;
    logic                       live;
    logic                       rd_vld;
    logic                       acc_q;
    logic [K_WIDTH-1:0]         k_len_q;
    logic [K_WIDTH-1:0]         cnt;
    logic [FC_W-1:0]            fcnt;
    logic [IDX_W-1:0]           idx;
    logic [BRAM_ADDR_WIDTH-1:0] a_addr, b_addr, c_addr;
    logic                       kill;

    assign kill = abort && (state != IDLE);

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) state <= IDLE;
        else                state <= state_next;
    end

    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        arr_clear  = 1'b0;
        bram_a_enb = 1'b0;
        bram_b_enb = 1'b0;
        res_valid  = 1'b0;
        done       = 1'b0;
        busy       = (state != IDLE);
        unique case (state)
            IDLE: begin
                cmd_ready = live;
                if (cmd_valid && live) state_next = CLEAR;
            end
            CLEAR: begin
                arr_clear  = !acc_q;
                state_next = (k_len_q == '0) ? FLUSH : STREAM;
            end
            STREAM: begin
                bram_a_enb = 1'b1;
                bram_b_enb = 1'b1;
                if (cnt == k_len_q - K_WIDTH'(1)) state_next = FLUSH;
            end
            FLUSH: begin
                if (fcnt == FC_W'(FLUSH_CYCLES - 1)) state_next = DRAIN;
            end
            DRAIN: begin
                res_valid = 1'b1;
                if (res_ready && !abort && idx == IDX_W'(ARRAY_DIM * ARRAY_DIM - 1))
                    state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (kill) state_next = IDLE;
    end

    // Counters and latched command; address counters wrap naturally at 2^BRAM_ADDR_WIDTH.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            live    <= 1'b0;
            rd_vld  <= 1'b0;
            acc_q   <= 1'b0;
            k_len_q <= '0;
            cnt     <= '0;
            fcnt    <= '0;
            idx     <= '0;
            a_addr  <= '0;
            b_addr  <= '0;
            c_addr  <= '0;
        end else begin
            live   <= 1'b1;
            rd_vld <= (state == STREAM) && !kill;
            unique case (state)
                IDLE: if (cmd_valid && live) begin
                    acc_q   <= cmd_accumulate;
                    k_len_q <= cmd_k_len;
                    a_addr  <= cmd_a_base;
                    b_addr  <= cmd_b_base;
                    c_addr  <= cmd_c_base;
                    cnt     <= '0;
                    fcnt    <= '0;
                    idx     <= '0;
                end
                STREAM: begin
                    cnt    <= cnt + K_WIDTH'(1);
                    a_addr <= a_addr + BRAM_ADDR_WIDTH'(1);
                    b_addr <= b_addr + BRAM_ADDR_WIDTH'(1);
                end
                FLUSH: fcnt <= fcnt + FC_W'(1);
                DRAIN: if (res_ready && !abort) begin
                    idx    <= idx + IDX_W'(1);
                    c_addr <= c_addr + BRAM_ADDR_WIDTH'(1);
                end
                default: ;
            endcase
        end
    end

    assign bram_a_addrb = a_addr;
    assign bram_b_addrb = b_addr;
    assign res_addr     = c_addr;
    assign res_data     = res_valid ? arr_c_flat[idx*ACC_W +: ACC_W] : '0;

    sys_skew_line u_skew_a (
        .clk      (s_axi_aclk),
        .rst_n    (s_axi_aresetn),
        .flush    (kill),
        .in_valid (rd_vld),
        .din      (bram_a_doutb),
        .dout     (arr_a)
    );

    sys_skew_line u_skew_b (
        .clk      (s_axi_aclk),
        .rst_n    (s_axi_aresetn),
        .flush    (kill),
        .in_valid (rd_vld),
        .din      (bram_b_doutb),
        .dout     (arr_b)
    );

endmodule

// File: tb/tb_sys_tile_sched.sv
// Bench for sys_tile_sched: BRAM and a cycle-level 4x4 array stand-in around the
// DUT, results compared against table constants and a plain dot-product model.
module tb_sys_tile_sched;

    logic          clk = 1'b0;
    logic          s_axi_aresetn;
    logic          cmd_valid, cmd_ready, cmd_accumulate, abort;
    logic [10:0]   cmd_a_base, cmd_b_base, cmd_c_base;
    logic [15:0]   cmd_k_len;
    logic [10:0]   bram_a_addrb, bram_b_addrb, res_addr;
    logic          bram_a_enb, bram_b_enb, arr_clear, res_valid, res_ready, busy, done;
    logic [31:0]   bram_a_doutb, bram_b_doutb, arr_a, arr_b, res_data;
    logic [511:0]  arr_c_flat;

    always #5 clk = ~clk;

    sys_tile_sched dut (
        .s_axi_aclk(clk), .s_axi_aresetn(s_axi_aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a_base(cmd_a_base), .cmd_b_base(cmd_b_base), .cmd_c_base(cmd_c_base),
        .cmd_k_len(cmd_k_len), .cmd_accumulate(cmd_accumulate), .abort(abort),
        .bram_a_addrb(bram_a_addrb), .bram_b_addrb(bram_b_addrb),
        .bram_a_enb(bram_a_enb), .bram_b_enb(bram_b_enb),
        .bram_a_doutb(bram_a_doutb), .bram_b_doutb(bram_b_doutb),
        .arr_clear(arr_clear), .arr_a(arr_a), .arr_b(arr_b), .arr_c_flat(arr_c_flat),
        .res_valid(res_valid), .res_ready(res_ready), .res_addr(res_addr),
        .res_data(res_data), .busy(busy), .done(done)
    );

    // BRAM read ports, one cycle latency, output held when not enabled
    logic [31:0] mem_a [2048];
    logic [31:0] mem_b [2048];
    always @(posedge clk) begin
        if (bram_a_enb) bram_a_doutb <= mem_a[bram_a_addrb];
        if (bram_b_enb) bram_b_doutb <= mem_b[bram_b_addrb];
    end

    function automatic logic signed [31:0] mul8(input logic signed [7:0] x, input logic signed [7:0] y);
        logic signed [31:0] ex, ey;
        ex = x;
        ey = y;
        return ex * ey;
    endfunction

    // Output-stationary array: A moves right along rows, B moves down columns
    logic signed [7:0]  ar [4][4];
    logic signed [7:0]  br [4][4];
    logic signed [31:0] pe [16];
    always @(posedge clk) begin
        for (int r = 0; r < 4; r++) begin
            ar[r][0] <= arr_a[8*r +: 8];
            for (int c = 1; c < 4; c++) ar[r][c] <= ar[r][c-1];
        end
        for (int c = 0; c < 4; c++) begin
            br[0][c] <= arr_b[8*c +: 8];
            for (int r = 1; r < 4; r++) br[r][c] <= br[r-1][c];
        end
        for (int i = 0; i < 16; i++)
            pe[i] <= arr_clear ? 32'sd0 : pe[i] + mul8(ar[i/4][i%4], br[i/4][i%4]);
    end
    always_comb begin
        arr_c_flat = '0;
        for (int i = 0; i < 16; i++) arr_c_flat[i*32 +: 32] = pe[i];
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: C(r,c) = [previous C if accumulating] + sum_k A_k[r] * B_k[c]
    logic [31:0]        wa [16];
    logic [31:0]        wb [16];
    logic signed [31:0] model_c [16];

    task automatic model_apply(input bit accum, input int k);
        if (!accum) for (int i = 0; i < 16; i++) model_c[i] = 0;
        for (int j = 0; j < k; j++)
            for (int i = 0; i < 16; i++)
                model_c[i] = model_c[i] + mul8(wa[j][8*(i/4) +: 8], wb[j][8*(i%4) +: 8]);
    endtask

    typedef struct {
        logic [31:0] a_word;
        logic [31:0] b_word;
        int          k;
        logic [10:0] a_base;
        logic [10:0] b_base;
        logic [10:0] c_base;
        bit          accum;
        logic [31:0] exp_data;
        int          stall_at;
        int          stall_len;
        bit          skew;
    } vec_t;

    vec_t        tbl [6];
    logic [42:0] beats [$];
    logic [10:0] rd_a [$];
    logic [10:0] rd_b [$];
    logic [31:0] a_trace [$];
    int          issue_ix;

    task automatic run_cmd(input logic [10:0] ab, input logic [10:0] bb, input logic [10:0] cb,
                           input int k, input bit accum, input int stall_at, input int stall_len,
                           input bit rand_ready, input int abort_at, input bit rst_drain,
                           input bit use_tbl, input logic [31:0] texp);
        bit accepted = 0, aborted = 0, ab_chk = 0, rst_hit = 0, released = 0, rel_chk = 0, held = 0;
        int tail = -1, done_cnt = 0, clr_cnt = 0, stall_left = stall_len;
        logic [10:0] h_addr, ea;
        logic [31:0] h_data, ed;
        for (int j = 0; j < k; j++) begin
            ea = ab + 11'(j);
            mem_a[ea] = wa[j];
            ea = bb + 11'(j);
            mem_b[ea] = wb[j];
        end
        if (abort_at < 0 && !rst_drain) model_apply(accum, k);
        beats.delete(); rd_a.delete(); rd_b.delete(); a_trace.delete();
        issue_ix = -1;
        cmd_a_base = ab; cmd_b_base = bb; cmd_c_base = cb;
        cmd_k_len = 16'(k); cmd_accumulate = accum;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(posedge clk); #1;
            if (aborted && !ab_chk) begin
                check("abort_busy", 32'(busy), 0);
                check("abort_enb", 32'(bram_a_enb), 0);
                abort = 0; ab_chk = 1; tail = 5;
            end else if (abort_at >= 0 && !aborted && bram_a_enb && rd_a.size() == abort_at) begin
                abort = 1; aborted = 1;
            end
            cmd_valid = !accepted;
            if (stall_left > 0 && beats.size() == stall_at && res_valid) begin
                res_ready = 0; stall_left--;
            end else begin
                res_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            if (released && !rel_chk) begin
                check("rst_busy_after", 32'(busy), 0);
                check("rst_ready_after", 32'(cmd_ready), 1);
                rel_chk = 1; tail = 4;
            end else if (rst_hit && !released) begin
                s_axi_aresetn = 1; released = 1;
            end else if (rst_drain && !rst_hit && res_valid && beats.size() == 2) begin
                s_axi_aresetn = 0; rst_hit = 1;
                #1;
                check("rst_res_valid", 32'(res_valid), 0);
                check("rst_busy", 32'(busy), 0);
            end
            @(negedge clk);
            if (cmd_valid && cmd_ready) accepted = 1;
            if (bram_a_enb) begin
                if (rd_a.size() == 0) issue_ix = cyc;
                rd_a.push_back(bram_a_addrb);
                rd_b.push_back(bram_b_addrb);
            end
            a_trace.push_back(arr_a);
            if (arr_clear) clr_cnt++;
            if (done) done_cnt++;
            if (res_valid && res_ready && !abort && s_axi_aresetn) beats.push_back({res_addr, res_data});
            if (held && res_valid) begin
                check("stall_addr", 32'(res_addr), 32'(h_addr));
                check("stall_data", res_data, h_data);
            end
            held = res_valid && !res_ready; h_addr = res_addr; h_data = res_data;
            if (done && tail < 0) tail = 3;
            if (tail > 0) tail--;
            if (tail == 0) break;
        end
        check("run_end", 32'(tail == 0), 1);
        if (!aborted && !rst_hit) begin
            check("done_cnt", 32'(done_cnt), 1);
            check("beat_cnt", 32'(beats.size()), 16);
            check("clear_cnt", 32'(clr_cnt), 32'(!accum));
            check("read_cnt", 32'(rd_a.size()), 32'(k));
            for (int j = 0; j < rd_a.size() && j < k; j++) begin
                ea = ab + 11'(j);
                check("rd_a_addr", 32'(rd_a[j]), 32'(ea));
                ea = bb + 11'(j);
                check("rd_b_addr", 32'(rd_b[j]), 32'(ea));
            end
            for (int i = 0; i < beats.size() && i < 16; i++) begin
                ea = cb + 11'(i);
                ed = use_tbl ? texp : model_c[i];
                check("res_addr", 32'(beats[i][42:32]), 32'(ea));
                check("res_data", beats[i][31:0], ed);
            end
        end else begin
            check("no_done", 32'(done_cnt), 0);
        end
    endtask

    logic [31:0] sk;

    initial begin
        s_axi_aresetn = 0; cmd_valid = 0; abort = 0; res_ready = 1;
        cmd_a_base = 0; cmd_b_base = 0; cmd_c_base = 0; cmd_k_len = 0; cmd_accumulate = 0;
        for (int i = 0; i < 16; i++) model_c[i] = 0;

        tbl[0] = '{32'h01010101, 32'h02020202, 8, 11'h000, 11'h100, 11'h040, 1'b0, 32'h00000010, -1, 0, 1'b0};
        tbl[1] = '{32'h01010101, 32'h02020202, 8, 11'h000, 11'h100, 11'h040, 1'b1, 32'h00000020, -1, 0, 1'b0};
        tbl[2] = '{32'h01010101, 32'h02020202, 0, 11'h000, 11'h100, 11'h080, 1'b0, 32'h00000000, -1, 0, 1'b0};
        tbl[3] = '{32'hFFFFFFFF, 32'h01010101, 4, 11'h200, 11'h300, 11'h0C0, 1'b0, 32'hFFFFFFFC, 3, 5, 1'b0};
        tbl[4] = '{32'h04030201, 32'h00000000, 1, 11'h010, 11'h020, 11'h100, 1'b0, 32'h00000000, -1, 0, 1'b1};
        tbl[5] = '{32'h01010101, 32'h03030303, 4, 11'h7FE, 11'h7FD, 11'h7F8, 1'b0, 32'h0000000C, -1, 0, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl", 32'({cmd_ready, busy, done, res_valid, bram_a_enb, bram_b_enb, arr_clear}), 0);
        check("reset_arr_a", arr_a, 0);
        check("reset_res_data", res_data, 0);
        s_axi_aresetn = 1;
        @(posedge clk); #1;
        check("ready_after_reset", 32'(cmd_ready), 1);

        for (int t = 0; t < 6; t++) begin
            for (int j = 0; j < 16; j++) begin wa[j] = tbl[t].a_word; wb[j] = tbl[t].b_word; end
            run_cmd(tbl[t].a_base, tbl[t].b_base, tbl[t].c_base, tbl[t].k, tbl[t].accum,
                    tbl[t].stall_at, tbl[t].stall_len, 1'b0, -1, 1'b0, 1'b1, tbl[t].exp_data);
            if (tbl[t].skew) begin
                check("skew_issue_seen", 32'(issue_ix >= 0), 1);
                for (int c = issue_ix; c >= 0 && c <= issue_ix + 6 && c < a_trace.size(); c++) begin
                    sk = 0;
                    for (int i = 0; i < 4; i++) if (c == issue_ix + 1 + i) sk[8*i +: 8] = 8'(i + 1);
                    check("skew_arr_a", a_trace[c], sk);
                end
            end
        end

        // abort mid-stream, then a clean command
        for (int j = 0; j < 16; j++) begin wa[j] = $urandom; wb[j] = $urandom; end
        run_cmd(11'h010, 11'h020, 11'h300, 6, 1'b0, -1, 0, 1'b0, 2, 1'b0, 1'b0, 0);
        for (int j = 0; j < 16; j++) begin wa[j] = tbl[0].a_word; wb[j] = tbl[0].b_word; end
        run_cmd(11'h000, 11'h100, 11'h040, 8, 1'b0, -1, 0, 1'b0, -1, 1'b0, 1'b1, 32'h00000010);

        // reset during drain, then a fresh randomized command
        for (int j = 0; j < 16; j++) begin wa[j] = $urandom; wb[j] = $urandom; end
        run_cmd(11'h050, 11'h060, 11'h200, 3, 1'b0, -1, 0, 1'b0, -1, 1'b1, 1'b0, 0);
        for (int j = 0; j < 16; j++) begin wa[j] = $urandom; wb[j] = $urandom; end
        run_cmd(11'h123, 11'h456, 11'h389, 5, 1'b0, -1, 0, 1'b1, -1, 1'b0, 1'b0, 0);

        for (int n = 0; n < 12; n++) begin
            for (int j = 0; j < 16; j++) begin wa[j] = $urandom; wb[j] = $urandom; end
            run_cmd(11'($urandom), 11'($urandom), 11'($urandom), $urandom_range(0, 16),
                    1'($urandom_range(0, 1)), -1, 0, 1'b1, -1, 1'b0, 1'b0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sys_tile_sched.md
Name: sys_tile_sched

Overview:
Sequencer for one 4x4 int8 tile matmul on the systolic array. It accepts a tile command, streams K words from BRAM A/B, and applies the per-lane diagonal skew with zero fill. It then flushes the array and drains all 16 int32 results to a C-writer over valid/ready. It sits between the AXI-Lite control block and the array/BRAM ports, so software only programs bases, K and start.

Parameters:
BRAM_ADDR_WIDTH, 11, BRAM word-address width for A/B/C.
K_WIDTH, 16, width of the tile reduction length.
FLUSH_CYCLES, 11, cycles after the last read issue before results are stable: 1 BRAM + 3 skew + 6 hops + 1 margin.

Ports:
s_axi_aclk  in  1  sole clock
s_axi_aresetn  in  1  asynchronous active-low reset
cmd_valid  in  1  tile command valid
cmd_ready  out  1  high only in IDLE
cmd_a_base  in  BRAM_ADDR_WIDTH  first A word address
cmd_b_base  in  BRAM_ADDR_WIDTH  first B word address
cmd_c_base  in  BRAM_ADDR_WIDTH  first C result address
cmd_k_len  in  K_WIDTH  words to stream (0 allowed)
cmd_accumulate  in  1  1 = skip array clear
abort  in  1  synchronous abort
bram_a_addrb/bram_b_addrb  out  BRAM_ADDR_WIDTH  read addresses
bram_a_enb/bram_b_enb  out  1  read enables
bram_a_doutb/bram_b_doutb  in  32  read data, 4 signed int8 lanes, lane i = bits [8i+7:8i]
arr_clear  out  1  array accumulator clear
arr_a/arr_b  out  32  skewed lane outputs to the array
arr_c_flat  in  512  results; c(r,c) at bits [(4r+c)*32 +: 32]
res_valid  out  1  result beat valid
res_ready  in  1  writer accepts the beat
res_addr  out  BRAM_ADDR_WIDTH  C address for the beat
res_data  out  32  result word
busy  out  1  state != IDLE
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (async assert, sync release): state=IDLE, all outputs 0, skew pipes 0, counters 0. cmd_ready rises the first cycle after release.
- Command capture: on cmd_valid&cmd_ready, latch all cmd_* fields and go to CLEAR.
- CLEAR, 1 cycle: arr_clear=1 unless accumulate=1. Next state is STREAM, or FLUSH if k_len=0.
- STREAM, k_len cycles: enb=1; addr=base+cnt modulo 2^BRAM_ADDR_WIDTH. After the last issue, go to FLUSH.
- Lane pipeline:
  - Read data is valid 1 cycle after issue.
  - Lane i is delayed a further i cycles (0..3).
  - Any lane slot without valid data drives 8'h00, so the array never accumulates stale bytes.
- FLUSH: FLUSH_CYCLES cycles with enb=0, then DRAIN.
- DRAIN:
  - idx runs 0..15; res_valid=1; res_data=arr_c_flat[idx*32 +: 32]; res_addr=c_base+idx, wrapping.
  - idx advances only on res_valid&res_ready.
  - While valid&!ready, data and addr are held stable.
  - On the transfer with idx=15, go to DONE.
- DONE, 1 cycle: done=1, then IDLE.
- Abort:
  - In any non-IDLE state, the next state is IDLE.
  - enb, res_valid and arr_clear drop that edge; skew pipes are zeroed; no done pulse.
  - Abort in IDLE has no effect.
  - If abort and a result handshake coincide, abort wins and that beat counts as not transferred.
- cmd_valid outside IDLE is ignored; no queueing.
- Async reset mid-operation: immediate return to reset values with no done pulse.

Decomposition:
- Shared package sys_pkg: state encoding (IDLE, CLEAR, STREAM, FLUSH, DRAIN, DONE), ARRAY_DIM=4, LANE_W=8, ACC_W=32.
- Sub-module sys_skew_line: 4-lane int8 delay line with per-lane valid and zero fill, lane i delay i. Instantiated twice, for A and B, with a synchronous flush input.

Test Plan:
- All-ones/twos: A words 0x01010101, B words 0x02020202, k_len=8, c_base=0x40, res_ready=1 -> 16 beats, data 0x00000010, addr 0x40..0x4F, then exactly one done pulse.
- Signed product plus backpressure: A=0xFFFFFFFF, B=0x01010101, k_len=4; hold res_ready=0 for 5 cycles at idx 3 -> all 16 beats carry 0xFFFFFFFC; addr/data stable while stalled; exactly 16 transfers.
- Skew timing: k_len=1, A word 0x04030201 -> arr_a lane i equals i+1 exactly at cycle T+i, where T = issue cycle + 1; every other lane slot is 0.
- Accumulate and k_len=0:
  - Run test 1, then the same command with accumulate=1 -> results 0x00000020; arr_clear never asserted.
  - Then k_len=0 with accumulate=0 -> 16 zero beats.
- Wrap: c_base=0x7F8, a_base=0x7FE, k_len=4 -> read addr 0x7FE, 0x7FF, 0x000, 0x001; res_addr 0x7F8..0x7FF, 0x000..0x007.
- Abort and reset:
  - Abort during STREAM at cnt=2 -> IDLE next cycle, enb=0, no done; a following command completes correctly.
  - Assert s_axi_aresetn low mid-DRAIN -> res_valid=0 immediately; busy=0 after release.
